// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    localparam int USR_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/usr_next_mux.sv
// Combinational next-state selector: hold, shift right/left with serial-in from din, or load.
import usr_pkg::*;

module usr_next_mux #(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    input  usr_mode_e          mode,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   next_q
);

    always_comb begin
        next_q = q;
        case (mode)
            USR_HOLD: next_q = q;
            // Serial-in comes from the din bit that sits at the entry end.
            USR_SHR:  next_q = {din[WIDTH-1], q[WIDTH-1:1]};
            USR_SHL:  next_q = {q[WIDTH-2:0], din[0]};
            USR_LOAD: next_q = din;
            default:  next_q = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register top: state register with synchronous clear.
// Optional simulation checks are compiled when USR_ASSERT_EN is defined.
import usr_pkg::*;

module universal_shift_reg #(
    parameter int WIDTH = USR_DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] DATAOUT,
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATAIN
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next_q;
    usr_mode_e        w_mode;

    assign w_mode  = usr_mode_e'(MODE);
    assign DATAOUT = r_q;

    usr_next_mux #(.WIDTH(WIDTH)) u_next_mux (
        .mode   (w_mode),
        .q      (r_q),
        .din    (DATAIN),
        .next_q (w_next_q)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next_q;
        end
    end

`ifdef USR_ASSERT_EN
    logic             r_chk_vld;
    logic             r_prev_rst;
    usr_mode_e        r_prev_mode;
    logic [WIDTH-1:0] r_prev_q;
    logic [WIDTH-1:0] r_prev_din;

    // r_prev_* capture what the previous edge saw; r_q now holds its result.
    always_ff @(posedge clock) begin
        r_chk_vld   <= 1'b1;
        r_prev_rst  <= reset;
        r_prev_mode <= w_mode;
        r_prev_q    <= r_q;
        r_prev_din  <= DATAIN;
        if (!reset) begin
            assert (!$isunknown({MODE, DATAIN}))
                else $error("usr: X/Z on MODE or DATAIN");
        end
        if (r_chk_vld === 1'b1) begin
            if (r_prev_rst) begin
                assert (r_q == '0) else $error("usr: nonzero after reset");
            end else begin
                case (r_prev_mode)
                    USR_HOLD: assert (r_q == r_prev_q)
                        else $error("usr: hold changed value");
                    USR_SHR:  assert (r_q == {r_prev_din[WIDTH-1], r_prev_q[WIDTH-1:1]})
                        else $error("usr: shift right result wrong");
                    USR_SHL:  assert (r_q == {r_prev_q[WIDTH-2:0], r_prev_din[0]})
                        else $error("usr: shift left result wrong");
                    USR_LOAD: assert (r_q == r_prev_din)
                        else $error("usr: load result wrong");
                    default: ;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: driver queues expected values, monitor compares after each edge.
module tb_universal_shift_reg;

    localparam int W = 4;

    typedef struct {
        logic         rst;
        logic [1:0]   mode;
        logic [W-1:0] din;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        string        name;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [1:0]   MODE;
    logic [W-1:0] DATAIN;
    logic [W-1:0] DATAOUT;

    exp_t sb_q[$];
    int   n_vec;
    int   n_fail;

    universal_shift_reg #(.WIDTH(W)) dut (
        .DATAOUT (DATAOUT),
        .clock   (clock),
        .reset   (reset),
        .MODE    (MODE),
        .DATAIN  (DATAIN)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t vecs[] = '{
        '{1'b1, 2'b11, 4'b1111, 4'b0000, "reset_over_load"},
        '{1'b0, 2'b00, 4'b0000, 4'b0000, "hold_after_reset"},
        '{1'b0, 2'b11, 4'b1010, 4'b1010, "load_1010"},
        '{1'b0, 2'b00, 4'b0101, 4'b1010, "hold_1"},
        '{1'b0, 2'b00, 4'b0101, 4'b1010, "hold_2"},
        '{1'b0, 2'b00, 4'b0101, 4'b1010, "hold_3"},
        '{1'b1, 2'b00, 4'b0000, 4'b0000, "reset_before_shr"},
        '{1'b0, 2'b01, 4'b0011, 4'b0000, "shr_zero_in_1"},
        '{1'b0, 2'b01, 4'b0011, 4'b0000, "shr_zero_in_2"},
        '{1'b0, 2'b11, 4'b1010, 4'b1010, "load_for_shr"},
        '{1'b0, 2'b01, 4'b1000, 4'b1101, "shr_one_in_1"},
        '{1'b0, 2'b01, 4'b1000, 4'b1110, "shr_one_in_2"},
        '{1'b1, 2'b00, 4'b0000, 4'b0000, "reset_before_shl"},
        '{1'b0, 2'b10, 4'b0111, 4'b0001, "shl_1"},
        '{1'b0, 2'b10, 4'b0111, 4'b0011, "shl_2"},
        '{1'b0, 2'b10, 4'b0111, 4'b0111, "shl_3"},
        '{1'b0, 2'b10, 4'b0111, 4'b1111, "shl_4"},
        '{1'b0, 2'b10, 4'b0000, 4'b1110, "shl_msb_lost"},
        '{1'b0, 2'b11, 4'b1010, 4'b1010, "load_before_midrst"},
        '{1'b1, 2'b10, 4'b0111, 4'b0000, "reset_mid_shl"},
        '{1'b0, 2'b11, 4'b0110, 4'b0110, "resume_load_0110"},
        '{1'b0, 2'b11, 4'b1001, 4'b1001, "mix_load"},
        '{1'b0, 2'b01, 4'b0000, 4'b0100, "mix_shr"},
        '{1'b0, 2'b10, 4'b0001, 4'b1001, "mix_shl"},
        '{1'b0, 2'b00, 4'b1111, 4'b1001, "mix_hold"}
    };

    // Monitor: one result is presented after every edge that had a queued operation.
    always begin
        @(posedge clock);
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (DATAOUT !== e.exp) begin
                n_fail++;
                $display("FAIL %s: DATAOUT=%b expected=%b", e.name, DATAOUT, e.exp);
            end
        end
    end

    task automatic apply(input vec_t v);
        @(negedge clock);
        reset  = v.rst;
        MODE   = v.mode;
        DATAIN = v.din;
        sb_q.push_back('{v.exp, v.name});
    endtask

    initial begin
        int budget;
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        MODE   = 2'b00;
        DATAIN = '0;
        foreach (vecs[i]) apply(vecs[i]);

        // Inputs that toggle between edges must not disturb the held value.
        @(negedge clock);
        reset  = 1'b0;
        MODE   = 2'b00;
        DATAIN = 4'b0000;
        sb_q.push_back('{4'b1001, "glitch_between_edges"});
        #2 MODE = 2'b11; DATAIN = 4'b0110;
        #1 MODE = 2'b00; DATAIN = 4'b0000;

        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
